// File: rtl/wb2axi_bridge.sv
// Wishbone classic slave to single-beat AXI4 master bridge.
// Each 32-bit Wishbone access becomes one AXI write (AW+W->B) or one AXI read
// (AR->R) on a 64-bit data bus. Only one transaction is in flight at a time.
module wb2axi_bridge #(
  parameter int          AW       = 12,
  parameter int          ID_WIDTH = 1,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  // Wishbone slave
  input  logic [AW-1:0]       i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic [3:0]          i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [31:0]         o_wb_rdt,
  output logic                o_wb_ack,
  output logic                o_wb_err,
  // AXI write address
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [AW-1:0]       o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  // AXI write data
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  // AXI write response
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  // AXI read address
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [AW-1:0]       o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  // AXI read data
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_BRESP,
    S_READ,
    S_RRESP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;

  // Control registers (reset)
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q,  wvalid_d;
  logic        bready_q,  bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q,  rready_d;
  logic        err_q,     err_d;
  logic [31:0] rdt_q,     rdt_d;

  // Request datapath registers (no reset: only consumed after a valid request)
  logic [AW-1:0] addr_q,  addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wstrb_q, wstrb_d;
  logic          hi_q,    hi_d;

  // Handshake-completion terms for the independent AW and W channels
  logic aw_ok;
  logic w_ok;

  // Bits of the inputs that carry no meaning for this bridge
  logic unused_inputs;
  assign unused_inputs = ^{i_rlast, i_wb_adr[1:0], i_bresp[0], i_rresp[0]};

  assign aw_ok = !awvalid_q || i_awready;
  assign w_ok  = !wvalid_q  || i_wready;

  // Next-state and next-value logic for the transaction FSM
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_d     = err_q;
    rdt_d     = rdt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    hi_d      = hi_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          addr_d  = {i_wb_adr[AW-1:2], 2'b00};
          hi_d    = i_wb_adr[2];
          wdata_d = {i_wb_dat, i_wb_dat};
          wstrb_d = i_wb_adr[2] ? {i_wb_sel, 4'h0} : {4'h0, i_wb_sel};
          err_d   = 1'b0;
          if (i_wb_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_READ;
          end
        end
      end

      S_WRITE: begin
        // AW and W retire independently; B is opened once both are gone
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = S_BRESP;
        end
      end

      S_BRESP: begin
        if (i_bvalid) begin
          bready_d = 1'b0;
          err_d    = i_bresp[1];
          state_d  = S_DONE;
        end
      end

      S_READ: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RRESP;
        end
      end

      S_RRESP: begin
        // Read data is captured even on an error response
        if (i_rvalid) begin
          rready_d = 1'b0;
          rdt_d    = hi_q ? i_rdata[63:32] : i_rdata[31:0];
          err_d    = i_rresp[1];
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        // Single response cycle; the Wishbone request is not resampled here
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register with synchronous reset; abandons any AXI transfer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
      rdt_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      err_q     <= err_d;
      rdt_q     <= rdt_d;
    end
  end

  // Request address/data/strobe registers, held stable until handshake
  always_ff @(posedge i_clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    hi_q    <= hi_d;
  end

  // Wishbone response: one cycle in DONE, suppressed if the cycle was aborted
  assign o_wb_ack = (state_q == S_DONE) && !err_q && i_wb_cyc;
  assign o_wb_err = (state_q == S_DONE) &&  err_q && i_wb_cyc;
  assign o_wb_rdt = rdt_q;

  // AXI write channels: single 32-bit beat within a 64-bit bus
  assign o_awid    = ID_WIDTH'(AXI_ID);
  assign o_awaddr  = addr_q;
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'b010;
  assign o_awburst = 2'b01;
  assign o_awvalid = awvalid_q;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = wvalid_q;
  assign o_bready  = bready_q;

  // AXI read channels
  assign o_arid    = ID_WIDTH'(AXI_ID);
  assign o_araddr  = addr_q;
  assign o_arlen   = 8'd0;
  assign o_arsize  = 3'b010;
  assign o_arburst = 2'b01;
  assign o_arvalid = arvalid_q;
  assign o_rready  = rready_q;

endmodule

// File: tb/tb_wb2axi_bridge.sv
// Directed bench for wb2axi_bridge: a cycle-stepped AXI responder inside each
// access task, with a scoreboard of expected Wishbone responses.
module tb_wb2axi_bridge;

  localparam int AW = 12;
  localparam int ID_WIDTH = 1;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [AW-1:0] i_wb_adr;
  logic [31:0]   i_wb_dat;
  logic [3:0]    i_wb_sel;
  logic          i_wb_we, i_wb_cyc, i_wb_stb;
  logic [31:0]   o_wb_rdt;
  logic          o_wb_ack, o_wb_err;
  logic [ID_WIDTH-1:0] o_awid, o_arid;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic [7:0]    o_awlen, o_arlen;
  logic [2:0]    o_awsize, o_arsize;
  logic [1:0]    o_awburst, o_arburst;
  logic          o_awvalid, i_awready;
  logic [63:0]   o_wdata;
  logic [7:0]    o_wstrb;
  logic          o_wlast, o_wvalid, i_wready;
  logic [1:0]    i_bresp;
  logic          i_bvalid, o_bready;
  logic          o_arvalid, i_arready;
  logic [63:0]   i_rdata;
  logic [1:0]    i_rresp;
  logic          i_rlast, i_rvalid, o_rready;

  always #5 clk = ~clk;

  wb2axi_bridge #(.AW(AW), .ID_WIDTH(ID_WIDTH), .AXI_ID(0)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  typedef struct {
    logic        is_err;
    logic        is_read;
    logic [31:0] rdt;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic idle_axi();
    i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
    i_bvalid = 1'b0; i_rvalid = 1'b0;
    i_bresp = 2'b00; i_rresp = 2'b00; i_rlast = 1'b0;
  endtask

  // One Wishbone access; readys rise at the given cycle (request = cycle 0).
  // abort_c >= 0 drops cyc/stb from that cycle on and expects no response.
  task automatic run_access(input string tag, input logic we, input logic [AW-1:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel,
                            input int aw_c, input int w_c, input int ar_c,
                            input logic [1:0] resp, input logic [63:0] rdata,
                            input int abort_c);
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int nresp = 0, both = 0, bready_early = 0, bready_first = -1;
    int done_c;
    logic bv = 1'b0, rv = 1'b0, drop = 1'b0;
    logic [AW-1:0] exp_addr, cap_awaddr = '0, cap_araddr = '0;
    logic [63:0]   cap_wdata = '0;
    logic [7:0]    cap_wstrb = '0;
    logic [7:0]    exp_strb;
    logic [31:0]   exp_rdt;
    exp_t e;

    exp_addr = adr;
    exp_addr[1:0] = 2'b00;
    exp_strb = adr[2] ? {sel, 4'h0} : {4'h0, sel};
    exp_rdt  = adr[2] ? rdata[63:32] : rdata[31:0];
    done_c   = we ? imax(imax(aw_c, 1), imax(w_c, 1)) + 2 : imax(ar_c, 1) + 2;
    if (abort_c < 0) sb.push_back('{resp[1], !we, exp_rdt, done_c});

    @(posedge clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;

    for (int k = 0; k < 24; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (drop || (abort_c >= 0 && k >= abort_c)) begin
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      end
      i_awready = (k >= aw_c);
      i_wready  = (k >= w_c);
      i_arready = (k >= ar_c);
      i_bvalid  = bv; i_bresp = resp;
      i_rvalid  = rv; i_rresp = resp; i_rdata = rdata;

      @(negedge clk);
      if (o_awvalid && i_awready) begin aw_hs++; cap_awaddr = o_awaddr; end
      if (o_wvalid && i_wready) begin w_hs++; cap_wdata = o_wdata; cap_wstrb = o_wstrb; end
      if (o_bready && (aw_hs == 0 || w_hs == 0)) bready_early++;
      if (o_bready && bready_first < 0) bready_first = k;
      if (o_bready && i_bvalid) begin b_hs++; bv = 1'b0; end
      else if (!bv && b_hs == 0 && aw_hs > 0 && w_hs > 0) bv = 1'b1;
      if (o_rready && i_rvalid) begin r_hs++; rv = 1'b0; end
      if (o_arvalid && i_arready) begin ar_hs++; cap_araddr = o_araddr; rv = 1'b1; end

      if (o_wb_ack || o_wb_err) begin
        nresp++;
        drop = 1'b1;
        if (o_wb_ack && o_wb_err) both++;
        check({tag, "_resp_expected"}, 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check({tag, "_ack"}, 64'(o_wb_ack), 64'(!e.is_err));
          check({tag, "_err"}, 64'(o_wb_err), 64'(e.is_err));
          check({tag, "_resp_cycle"}, 64'(k), 64'(e.cyc));
          if (e.is_read) check({tag, "_rdt"}, 64'(o_wb_rdt), 64'(e.rdt));
        end
      end
    end

    @(posedge clk); #1;
    idle_axi();
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;

    check({tag, "_resp_count"}, 64'(nresp), 64'((abort_c < 0) ? 1 : 0));
    check({tag, "_ack_and_err"}, 64'(both), 64'(0));
    if (we) begin
      check({tag, "_aw_hs"}, 64'(aw_hs), 64'(1));
      check({tag, "_w_hs"}, 64'(w_hs), 64'(1));
      check({tag, "_b_hs"}, 64'(b_hs), 64'(1));
      check({tag, "_bready_early"}, 64'(bready_early), 64'(0));
      check({tag, "_bready_cycle"}, 64'(bready_first), 64'(done_c - 1));
      check({tag, "_awaddr"}, 64'(cap_awaddr), 64'(exp_addr));
      check({tag, "_wdata"}, cap_wdata, {dat, dat});
      check({tag, "_wstrb"}, 64'(cap_wstrb), 64'(exp_strb));
      check({tag, "_aw_consts"}, 64'({o_awlen, o_awsize, o_awburst, o_wlast, o_awid}),
            64'({8'd0, 3'b010, 2'b01, 1'b1, 1'b0}));
    end else begin
      check({tag, "_ar_hs"}, 64'(ar_hs), 64'(1));
      check({tag, "_r_hs"}, 64'(r_hs), 64'(1));
      check({tag, "_araddr"}, 64'(cap_araddr), 64'(exp_addr));
      check({tag, "_ar_consts"}, 64'({o_arlen, o_arsize, o_arburst, o_arid}),
            64'({8'd0, 3'b010, 2'b01, 1'b0}));
    end
  endtask

  initial begin
    logic seen;
    i_rst = 1'b1;
    i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0;
    i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    i_rdata = '0;
    idle_axi();

    // Power-on reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 64'({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_wb_ack, o_wb_err}),
          64'(0));
    check("reset_rdt", 64'(o_wb_rdt), 64'(0));
    @(posedge clk); #1;
    i_rst = 1'b0;

    // Minimum-latency accesses
    run_access("wr_upper", 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 64'h0, -1);
    run_access("rd_lower", 1'b0, 12'h008, 32'h0, 4'hF, 0, 0, 0, 2'b00,
               64'h11223344_55667788, -1);
    run_access("rd_upper", 1'b0, 12'h00C, 32'h0, 4'hF, 0, 0, 0, 2'b00,
               64'h11223344_55667788, -1);

    // Independent AW/W completion in both orders
    run_access("wr_w_first", 1'b1, 12'h011, 32'hA5A50F0F, 4'h3, 6, 4, 0, 2'b00, 64'h0, -1);
    run_access("wr_aw_first", 1'b1, 12'h01C, 32'h01234567, 4'hC, 2, 5, 0, 2'b00, 64'h0, -1);

    // Error responses
    run_access("wr_slverr", 1'b1, 12'h020, 32'hCAFEF00D, 4'h1, 0, 0, 0, 2'b10, 64'h0, -1);
    run_access("rd_decerr", 1'b0, 12'h024, 32'h0, 4'hF, 0, 0, 0, 2'b11,
               64'h89ABCDEF_76543210, -1);

    // Reset while waiting for the write response
    @(posedge clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_adr = 12'h040; i_wb_dat = 32'h5555AAAA; i_wb_sel = 4'hF;
    i_awready = 1'b1; i_wready = 1'b1; i_bvalid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (o_bready) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("rst_reached_bresp", 64'(seen), 64'(1));
    @(posedge clk); #1;
    i_rst = 1'b1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    idle_axi();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ctrl", 64'({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_wb_ack, o_wb_err}),
          64'(0));
    check("rst_mid_rdt", 64'(o_wb_rdt), 64'(0));
    @(posedge clk); #1;
    i_rst = 1'b0;

    run_access("wr_after_rst", 1'b1, 12'h030, 32'h13579BDF, 4'h6, 0, 0, 0, 2'b00, 64'h0, -1);

    // Wishbone cycle dropped while the AXI read is still pending
    run_access("rd_abort", 1'b0, 12'h008, 32'h0, 4'hF, 0, 0, 4, 2'b00,
               64'hFEEDFACE_0BADF00D, 2);

    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
